exception_ctrl: RTL
===================

Name: exception_ctrl

Overview:
- Exception/interrupt sequencer that drives the status register's `exception` and `rfe` strobes.
- Prioritises synchronous exception sources and maskable external interrupts, gating interrupts by the SR interrupt-enable bit.
- Latches the exception PC (EPC) and a cause code, flushes the pipeline and redirects the PC to a vector.
- On return-from-exception, restores the PC from EPC and pulses `rfe_o` to the SR.

Parameters:
- NIRQ, 4: number of external interrupt lines.
- PCW, 32: PC/address width.
- VEC_BASE, 32'h0000_0080: base of the exception vector table.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- irq  in  NIRQ  level-sensitive interrupt requests.
- irq_mask  in  NIRQ  per-line enable (1 = enabled).
- ie  in  1  interrupt enable from SR (IE_c).
- exc_priv  in  1  privileged instruction in user mode (from decode).
- exc_ill  in  1  illegal instruction.
- exc_sys  in  1  syscall.
- exc_ovf  in  1  arithmetic overflow.
- rfe_req  in  1  return-from-exception instruction decoded.
- pc_cur  in  PCW  PC of the faulting instruction.
- pc_next  in  PCW  PC of the next sequential instruction.
- exc_o  out  1  one-cycle strobe to SR `exception`.
- rfe_o  out  1  one-cycle strobe to SR `rfe`.
- flush  out  1  squash in-flight instructions.
- pc_load  out  1  PC redirect valid.
- pc_target  out  PCW  redirect address.
- epc  out  PCW  saved exception PC.
- cause  out  5  cause code of last exception.
- irq_ack  out  NIRQ  one-hot acknowledge of the taken interrupt.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=0, async): state=IDLE. exc_o, rfe_o, flush, pc_load, irq_ack, busy = 0; epc=0; cause=0; pc_target=0. Reset mid-sequence aborts immediately; no strobe completes.
- All outputs are registered (Moore, decoded from state and held registers).
- Event detect happens only in IDLE. Priority, highest first:
  - exc_priv → cause 1
  - exc_ill → cause 2
  - exc_sys → cause 3
  - exc_ovf → cause 4
  - lowest-index k with irq[k] & irq_mask[k] & ie → cause 8+k
- Synchronous exceptions are taken regardless of `ie`. Interrupts are taken only when ie=1.
- EPC capture:
  - causes 1, 2, 4: epc=pc_cur (instruction re-executes or is reported).
  - cause 3 and interrupts: epc=pc_next.
- Exception sequence (detect in cycle N):
  - N+1, state TAKE: exc_o=1, flush=1, irq_ack one-hot for an interrupt (0 otherwise); epc/cause already updated.
  - N+2, state VECTOR: pc_load=1, flush=1, pc_target = VEC_BASE + (cause << 4).
  - N+3: IDLE.
- RFE sequence (rfe_req in IDLE with no exception/interrupt pending, detect in cycle N):
  - N+1, state RFE: rfe_o=1, pc_load=1, flush=1, pc_target=epc.
  - N+2: IDLE. epc and cause are unchanged.
- Simultaneous rfe_req and any takeable event: the event wins; rfe_req is dropped (decode re-issues after flush).
- All inputs are ignored while busy=1. An irq still asserted on return to IDLE is re-evaluated against the current `ie`. SR clears IE on exc_o, so there is no re-entry until rfe.
- exc_o and rfe_o never assert in the same cycle and are each exactly one cycle wide.
- pc_target holds its last value when pc_load=0.
- Cause width is 5 bits, which limits NIRQ to 24 or fewer (8+NIRQ-1 ≤ 31). Vector offsets wrap modulo 2^PCW.

Decomposition:
- Shared package `exc_pkg`:
  - cause-code constants (CAUSE_NONE=0, CAUSE_PRIV=1, CAUSE_ILL=2, CAUSE_SYS=3, CAUSE_OVF=4, CAUSE_IRQ_BASE=8).
  - state encoding (IDLE, TAKE, VECTOR, RFE).
- One sub-module, `exc_prio_enc`: combinational priority encoder producing {take, cause, irq_onehot, epc_sel}.
- FSM and registers stay in `exception_ctrl`.

Test Plan:
- Reset released, irq[2]=1, mask=4'b0100, ie=1, pc_next=0x1004 → N+1 exc_o=1, irq_ack=4'b0100, cause=10, epc=0x1004; N+2 pc_load=1, pc_target=0x0120.
- exc_ill=1 and exc_sys=1 same cycle, pc_cur=0x2000, ie=0 → cause=2, epc=0x2000, pc_target=0x00A0; exactly one exc_o pulse.
- irq[0]=1, mask=1, ie=0 → no exc_o, busy stays 0. Raise ie=1 → exception taken with cause=8.
- After an exception with epc=0x3008, rfe_req=1 → N+1 rfe_o=1, pc_load=1, pc_target=0x3008; N+2 busy=0.
- rfe_req and exc_ovf same cycle → exc_o pulse with cause=4, no rfe_o. Inputs toggled during TAKE/VECTOR have no effect.
- rst asserted during VECTOR → all outputs 0 asynchronously, epc=0, state IDLE, no pc_load after release.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared definitions for the exception sequencer: cause codes, FSM states
// and the EPC source selector.
package exc_pkg;

    localparam logic [4:0] CAUSE_NONE     = 5'd0;
    localparam logic [4:0] CAUSE_PRIV     = 5'd1;
    localparam logic [4:0] CAUSE_ILL      = 5'd2;
    localparam logic [4:0] CAUSE_SYS      = 5'd3;
    localparam logic [4:0] CAUSE_OVF      = 5'd4;
    localparam logic [4:0] CAUSE_IRQ_BASE = 5'd8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TAKE   = 2'd1,
        ST_VECTOR = 2'd2,
        ST_RFE    = 2'd3
    } exc_state_e;

    // Faulting/reported instructions save their own PC; syscalls and
    // interrupts resume at the following instruction.
    typedef enum logic {
        EPC_CUR  = 1'b0,
        EPC_NEXT = 1'b1
    } epc_sel_e;

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational priority encoder: picks the highest-priority takeable event
// and reports its cause, interrupt one-hot and EPC source.
import exc_pkg::*;

module exc_prio_enc #(
    parameter int NIRQ = 4
) (
    input  logic [NIRQ-1:0] irq_i,
    input  logic [NIRQ-1:0] irq_mask_i,
    input  logic            ie_i,
    input  logic            exc_priv_i,
    input  logic            exc_ill_i,
    input  logic            exc_sys_i,
    input  logic            exc_ovf_i,
    output logic            take_o,
    output logic [4:0]      cause_o,
    output logic [NIRQ-1:0] irq_onehot_o,
    output epc_sel_e        epc_sel_o
);

    // Interrupt lines that are both enabled per-line and globally.
    logic [NIRQ-1:0] irq_hit;
    assign irq_hit = irq_i & irq_mask_i & {NIRQ{ie_i}};

    // Fixed priority: priv > ill > sys > ovf > lowest-index interrupt.
    always_comb begin
        take_o       = 1'b0;
        cause_o      = CAUSE_NONE;
        irq_onehot_o = '0;
        epc_sel_o    = EPC_CUR;
        if (exc_priv_i) begin
            take_o  = 1'b1;
            cause_o = CAUSE_PRIV;
        end else if (exc_ill_i) begin
            take_o  = 1'b1;
            cause_o = CAUSE_ILL;
        end else if (exc_sys_i) begin
            take_o    = 1'b1;
            cause_o   = CAUSE_SYS;
            epc_sel_o = EPC_NEXT;
        end else if (exc_ovf_i) begin
            take_o  = 1'b1;
            cause_o = CAUSE_OVF;
        end else if (|irq_hit) begin
            take_o    = 1'b1;
            epc_sel_o = EPC_NEXT;
            // Scan downward so the lowest set index is the last one written.
            for (int k = NIRQ - 1; k >= 0; k--) begin
                if (irq_hit[k]) begin
                    cause_o         = CAUSE_IRQ_BASE + 5'(k);
                    irq_onehot_o    = '0;
                    irq_onehot_o[k] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/exception_ctrl.sv
// Exception/interrupt sequencer. Detects events in IDLE, latches EPC and
// cause, strobes the SR, flushes and redirects the PC to the vector; on
// return-from-exception restores the PC from EPC. All outputs registered.
// NIRQ must not exceed 24 so that 8+NIRQ-1 fits the 5-bit cause.
import exc_pkg::*;

module exception_ctrl #(
    parameter int             NIRQ     = 4,
    parameter int             PCW      = 32,
    parameter logic [PCW-1:0] VEC_BASE = 32'h0000_0080
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NIRQ-1:0] irq,
    input  logic [NIRQ-1:0] irq_mask,
    input  logic            ie,
    input  logic            exc_priv,
    input  logic            exc_ill,
    input  logic            exc_sys,
    input  logic            exc_ovf,
    input  logic            rfe_req,
    input  logic [PCW-1:0]  pc_cur,
    input  logic [PCW-1:0]  pc_next,
    output logic            exc_o,
    output logic            rfe_o,
    output logic            flush,
    output logic            pc_load,
    output logic [PCW-1:0]  pc_target,
    output logic [PCW-1:0]  epc,
    output logic [4:0]      cause,
    output logic [NIRQ-1:0] irq_ack,
    output logic            busy,
    output exc_state_e      state_dbg
);

    logic            take_d;
    logic [4:0]      cause_d;
    logic [NIRQ-1:0] onehot_d;
    epc_sel_e        epc_sel_d;

    exc_state_e      state_q;
    logic            exc_q, rfe_q, flush_q, pc_load_q, busy_q;
    logic [PCW-1:0]  pc_target_q, epc_q;
    logic [4:0]      cause_q;
    logic [NIRQ-1:0] irq_ack_q;

    exc_prio_enc #(.NIRQ(NIRQ)) u_prio (
        .irq_i        (irq),
        .irq_mask_i   (irq_mask),
        .ie_i         (ie),
        .exc_priv_i   (exc_priv),
        .exc_ill_i    (exc_ill),
        .exc_sys_i    (exc_sys),
        .exc_ovf_i    (exc_ovf),
        .take_o       (take_d),
        .cause_o      (cause_d),
        .irq_onehot_o (onehot_d),
        .epc_sel_o    (epc_sel_d)
    );

    // Sequencer FSM with registered Moore outputs; inputs only sampled in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            exc_q       <= 1'b0;
            rfe_q       <= 1'b0;
            flush_q     <= 1'b0;
            pc_load_q   <= 1'b0;
            busy_q      <= 1'b0;
            pc_target_q <= '0;
            epc_q       <= '0;
            cause_q     <= CAUSE_NONE;
            irq_ack_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (take_d) begin
                        // An event always beats a simultaneous rfe_req.
                        state_q   <= ST_TAKE;
                        exc_q     <= 1'b1;
                        flush_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        irq_ack_q <= onehot_d;
                        cause_q   <= cause_d;
                        epc_q     <= (epc_sel_d == EPC_NEXT) ? pc_next : pc_cur;
                    end else if (rfe_req) begin
                        state_q     <= ST_RFE;
                        rfe_q       <= 1'b1;
                        pc_load_q   <= 1'b1;
                        flush_q     <= 1'b1;
                        busy_q      <= 1'b1;
                        pc_target_q <= epc_q;
                    end
                end
                ST_TAKE: begin
                    state_q     <= ST_VECTOR;
                    exc_q       <= 1'b0;
                    irq_ack_q   <= '0;
                    pc_load_q   <= 1'b1;
                    pc_target_q <= VEC_BASE + (PCW'(cause_q) << 4);
                end
                ST_VECTOR, ST_RFE: begin
                    state_q   <= ST_IDLE;
                    exc_q     <= 1'b0;
                    rfe_q     <= 1'b0;
                    flush_q   <= 1'b0;
                    pc_load_q <= 1'b0;
                    busy_q    <= 1'b0;
                    irq_ack_q <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign exc_o     = exc_q;
    assign rfe_o     = rfe_q;
    assign flush     = flush_q;
    assign pc_load   = pc_load_q;
    assign pc_target = pc_target_q;
    assign epc       = epc_q;
    assign cause     = cause_q;
    assign irq_ack   = irq_ack_q;
    assign busy      = busy_q;
    assign state_dbg = state_q;

endmodule
